shared_mem_arbiter: RTL and testbench

SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

---
 rtl/gpu_pkg.sv | 21 ++
 rtl/rr_pick.sv | 31 +++
 rtl/shared_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_shared_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared definitions for the gpu memory subsystem: default widths, arbiter state
// encoding and an id-width helper.
package gpu_pkg;

    localparam int unsigned NumCoresDef = 4;
    localparam int unsigned AddrWDef    = 12;
    localparam int unsigned DataWDef    = 8;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StIssue = 2'd1;
    localparam state_t StWait  = 2'd2;
    localparam state_t StResp  = 2'd3;

    // Width of a core id; never zero so a single-core build still has a legal vector.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester found searching upward from
// last_grant + 1, wrapping modulo NUM_CORES.
module rr_pick
    import gpu_pkg::*;
#(
    parameter int unsigned NUM_CORES = NumCoresDef,
    parameter int unsigned ID_W      = id_width(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [ID_W-1:0]      last_grant,
    output logic [ID_W-1:0]      winner,
    output logic                 any
);

    int idx;

    assign any = |req;

    // Scan farthest-first so the nearest requester after last_grant is the final assignment.
    always_comb begin
        winner = '0;
        idx    = 0;
        for (int i = int'(NUM_CORES); i >= 1; i--) begin
            idx = (int'(last_grant) + i) % int'(NUM_CORES);
            if (req[idx]) begin
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Arbitrates per-core load/store requests onto a single shared-memory port,
// one access at a time, round-robin between requesting cores.
module shared_mem_arbiter
    import gpu_pkg::*;
#(
    parameter int unsigned NUM_CORES = NumCoresDef,
    parameter int unsigned ADDR_W    = AddrWDef,
    parameter int unsigned DATA_W    = DataWDef
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        req_ld,
    input  logic [NUM_CORES-1:0]        req_st,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        val_data,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        proto_err
);

    localparam int unsigned IdW = id_width(NUM_CORES);

    state_t                 state_q, state_d;
    logic [IdW-1:0]         last_grant_q, last_grant_d;
    logic [IdW-1:0]         win_q, win_d;
    logic                   op_q, op_d;
    logic [NUM_CORES-1:0]   val_data_q, val_data_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   mem_en_q, mem_en_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic                   proto_err_q, proto_err_d;

    logic [NUM_CORES-1:0]   req;
    logic [IdW-1:0]         pick_id;
    logic                   pick_any;

    assign req = req_ld | req_st;

    rr_pick #(
        .NUM_CORES (NUM_CORES),
        .ID_W      (IdW)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .winner     (pick_id),
        .any        (pick_any)
    );

    // mem_addr_q / mem_wdata_q double as the latched request; they only load on leaving idle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        op_d         = op_q;
        val_data_d   = '0;
        rdata_d      = rdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        proto_err_d  = proto_err_q;

        case (state_q)
            StIdle: begin
                proto_err_d = proto_err_q | (|(req_ld & req_st));
                if (pick_any) begin
                    win_d       = pick_id;
                    op_d        = req_st[pick_id] & ~req_ld[pick_id];
                    mem_en_d    = 1'b1;
                    mem_we_d    = req_st[pick_id] & ~req_ld[pick_id];
                    mem_addr_d  = core_addr[pick_id*ADDR_W +: ADDR_W];
                    mem_wdata_d = core_wdata[pick_id*DATA_W +: DATA_W];
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (!op_q) begin
                    rdata_d = mem_rdata;
                end
                val_data_d[win_q] = 1'b1;
                state_d           = StResp;
            end
            StResp: begin
                last_grant_d = win_q;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= IdW'(NUM_CORES - 1);
            win_q        <= '0;
            op_q         <= 1'b0;
            val_data_q   <= '0;
            rdata_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            op_q         <= op_d;
            val_data_q   <= val_data_d;
            rdata_q      <= rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign val_data  = val_data_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized phase checked against a transaction-level round-robin model.
module tb_shared_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_ld, req_st;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdata;
    logic [N-1:0]    val_data;
    logic [DW-1:0]   rdata;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic            ovr_en  = 1'b0;
    logic [7:0]      ovr_val = 8'h00;

    typedef struct {
        int          core;
        logic        ld;
        logic        st;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  mem;
        logic [3:0]  exp_val;
        logic        exp_we;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[6];
    int   exp_order[4];

    always #5 clk = ~clk;

    shared_mem_arbiter #(
        .NUM_CORES (N),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_ld     (req_ld),
        .req_st     (req_st),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .val_data   (val_data),
        .rdata      (rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .proto_err  (proto_err)
    );

    function automatic logic [7:0] mem_fn(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h5A;
    endfunction

    // Memory model: read data appears one cycle after the address is presented.
    always @(posedge clk) mem_rdata <= ovr_en ? ovr_val : mem_fn(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int k, input logic ld, input logic st,
                            input logic [11:0] a, input logic [7:0] d);
        req_ld[k]             = ld;
        req_st[k]             = st;
        core_addr[k*AW +: AW] = a;
        core_wdata[k*DW +: DW] = d;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req_ld = '0;
        req_st = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string p);
        chk({p, "_val_data"},  32'(val_data),  32'(0));
        chk({p, "_rdata"},     32'(rdata),     32'(0));
        chk({p, "_mem_en"},    32'(mem_en),    32'(0));
        chk({p, "_mem_we"},    32'(mem_we),    32'(0));
        chk({p, "_mem_addr"},  32'(mem_addr),  32'(0));
        chk({p, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
        chk({p, "_proto_err"}, 32'(proto_err), 32'(0));
    endtask

    // Single-requester transaction issued from idle; fixed cycle timing is expected.
    task automatic run_vec(input vec_t v);
        ovr_en  = 1'b1;
        ovr_val = v.mem;
        set_core(v.core, v.ld, v.st, v.addr, v.wdata);
        tick();
        chk("vec_issue_en",   32'(mem_en),   32'(1));
        chk("vec_issue_we",   32'(mem_we),   32'(v.exp_we));
        chk("vec_issue_addr", 32'(mem_addr), 32'(v.addr));
        chk("vec_issue_val",  32'(val_data), 32'(0));
        if (v.st && !v.ld) chk("vec_issue_wdata", 32'(mem_wdata), 32'(v.wdata));
        set_core(v.core, v.ld, v.st, ~v.addr, ~v.wdata);
        tick();
        chk("vec_wait_en",   32'(mem_en),   32'(0));
        chk("vec_wait_val",  32'(val_data), 32'(0));
        chk("vec_wait_addr", 32'(mem_addr), 32'(v.addr));
        tick();
        chk("vec_resp_val",   32'(val_data), 32'(v.exp_val));
        chk("vec_resp_rdata", 32'(rdata),    32'(v.exp_rdata));
        req_ld[v.core] = 1'b0;
        req_st[v.core] = 1'b0;
        tick();
        chk("vec_pulse_once", 32'(val_data), 32'(0));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t c_vec;
        int   got, cyc, last_cyc, idx, rearm;

        reset      = 1'b1;
        req_ld     = '0;
        req_st     = '0;
        core_addr  = '0;
        core_wdata = '0;

        vecs[0] = '{core: 2, ld: 1'b1, st: 1'b0, addr: 12'h3A5, wdata: 8'h00, mem: 8'h7C,
                    exp_val: 4'b0100, exp_we: 1'b0, exp_rdata: 8'h7C};
        vecs[1] = '{core: 1, ld: 1'b0, st: 1'b1, addr: 12'h010, wdata: 8'hEE, mem: 8'h55,
                    exp_val: 4'b0010, exp_we: 1'b1, exp_rdata: 8'h7C};
        vecs[2] = '{core: 3, ld: 1'b1, st: 1'b0, addr: 12'hFFF, wdata: 8'h00, mem: 8'h01,
                    exp_val: 4'b1000, exp_we: 1'b0, exp_rdata: 8'h01};
        vecs[3] = '{core: 0, ld: 1'b1, st: 1'b0, addr: 12'h000, wdata: 8'h00, mem: 8'hA5,
                    exp_val: 4'b0001, exp_we: 1'b0, exp_rdata: 8'hA5};
        vecs[4] = '{core: 0, ld: 1'b0, st: 1'b1, addr: 12'h800, wdata: 8'h00, mem: 8'h33,
                    exp_val: 4'b0001, exp_we: 1'b1, exp_rdata: 8'hA5};
        vecs[5] = '{core: 2, ld: 1'b0, st: 1'b1, addr: 12'hFFF, wdata: 8'hFF, mem: 8'h99,
                    exp_val: 4'b0100, exp_we: 1'b1, exp_rdata: 8'hA5};
        exp_order = '{0, 3, 0, 3};

        do_reset();
        check_reset_outputs("rst");

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // All four cores request loads in the same cycle after reset.
        do_reset();
        ovr_en = 1'b0;
        for (int k = 0; k < N; k++) set_core(k, 1'b1, 1'b0, 12'(k * 291 + 5), 8'h00);
        got = 0; cyc = 0; last_cyc = 0;
        while (got < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (val_data != '0) begin
                idx = 0;
                for (int k = 0; k < N; k++) if (val_data[k]) idx = k;
                chk("all4_onehot",  32'($countones(val_data)), 32'(1));
                chk("all4_order",   32'(idx), 32'(got));
                chk("all4_rdata",   32'(rdata), 32'(mem_fn(12'(idx * 291 + 5))));
                chk("all4_spacing", 32'(cyc - last_cyc), 32'((got == 0) ? 3 : 4));
                last_cyc    = cyc;
                req_ld[idx] = 1'b0;
                got++;
            end
        end
        chk("all4_count", 32'(got), 32'(4));

        // Cores 0 and 3 keep re-requesting; grants must alternate.
        set_core(0, 1'b1, 1'b0, 12'h0C0, 8'h00);
        set_core(3, 1'b1, 1'b0, 12'h3C0, 8'h00);
        got = 0; cyc = 0; rearm = -1;
        while (got < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (rearm >= 0) begin
                req_ld[rearm] = 1'b1;
                rearm = -1;
            end
            if (val_data != '0) begin
                idx = 0;
                for (int k = 0; k < N; k++) if (val_data[k]) idx = k;
                chk("alt_order", 32'(idx), 32'(exp_order[got]));
                req_ld[idx] = 1'b0;
                rearm = idx;
                got++;
            end
        end
        chk("alt_count", 32'(got), 32'(4));
        req_ld = '0;
        tick();

        // Load and store raised together: load wins, error flag is sticky.
        set_core(0, 1'b1, 1'b1, 12'h055, 8'h99);
        tick();
        chk("both_en",   32'(mem_en),    32'(1));
        chk("both_we",   32'(mem_we),    32'(0));
        chk("both_addr", 32'(mem_addr),  32'(12'h055));
        chk("both_err",  32'(proto_err), 32'(1));
        tick();
        tick();
        chk("both_val",   32'(val_data), 32'(4'b0001));
        chk("both_rdata", 32'(rdata),    32'(mem_fn(12'h055)));
        req_ld[0] = 1'b0;
        req_st[0] = 1'b0;
        tick();
        chk("both_err_hold", 32'(proto_err), 32'(1));
        c_vec = '{core: 1, ld: 1'b0, st: 1'b1, addr: 12'h222, wdata: 8'h44, mem: 8'h00,
                  exp_val: 4'b0010, exp_we: 1'b1, exp_rdata: mem_fn(12'h055)};
        run_vec(c_vec);
        chk("both_err_sticky", 32'(proto_err), 32'(1));

        // Reset during the wait cycle aborts the access and restores core-0 priority.
        ovr_en = 1'b0;
        set_core(2, 1'b1, 1'b0, 12'h2AA, 8'h00);
        tick();
        chk("abort_issue_en", 32'(mem_en), 32'(1));
        tick();
        chk("abort_wait_en",  32'(mem_en),   32'(0));
        chk("abort_wait_val", 32'(val_data), 32'(0));
        reset     = 1'b1;
        req_ld[2] = 1'b0;
        tick();
        reset = 1'b0;
        check_reset_outputs("abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_pulse", 32'(val_data), 32'(0));
        end
        set_core(0, 1'b1, 1'b0, 12'h0AA, 8'h00);
        set_core(2, 1'b1, 1'b0, 12'h2AA, 8'h00);
        tick();
        chk("abort_next_en",   32'(mem_en),   32'(1));
        chk("abort_next_addr", 32'(mem_addr), 32'(12'h0AA));
        tick();
        tick();
        chk("abort_next_val", 32'(val_data), 32'(4'b0001));
        req_ld[0] = 1'b0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (val_data != '0 && got == 0) begin
                chk("abort_second_val", 32'(val_data), 32'(4'b0100));
                req_ld[2] = 1'b0;
                got = 1;
            end
        end
        chk("abort_second_seen", 32'(got), 32'(1));

        // Randomized traffic against a transaction-level model.
        do_reset();
        ovr_en = 1'b0;
        begin
            int          e, free_edge, issue_edge, last, w, grants;
            int          m_id;
            logic        m_op;
            logic [11:0] m_addr;
            logic [7:0]  m_wd, m_rdata;
            logic        op;
            e = 0; free_edge = 0; issue_edge = -100; last = N - 1; grants = 0;
            m_id = 0; m_op = 1'b0; m_addr = '0; m_wd = '0; m_rdata = '0;
            for (int it = 0; it < 800; it++) begin
                tick();
                e++;
                if (e >= free_edge && (req_ld | req_st) != '0) begin
                    w = -1;
                    for (int i = 1; i <= N; i++) begin
                        if (w < 0 && (req_ld[(last + i) % N] || req_st[(last + i) % N]))
                            w = (last + i) % N;
                    end
                    m_id       = w;
                    m_op       = req_st[w] & ~req_ld[w];
                    m_addr     = core_addr[w*AW +: AW];
                    m_wd       = core_wdata[w*DW +: DW];
                    issue_edge = e;
                    free_edge  = e + 4;
                    last       = w;
                end
                chk("rnd_mem_en", 32'(mem_en), 32'(e == issue_edge));
                if (e == issue_edge) begin
                    chk("rnd_mem_we",   32'(mem_we),   32'(m_op));
                    chk("rnd_mem_addr", 32'(mem_addr), 32'(m_addr));
                    if (m_op) chk("rnd_mem_wdata", 32'(mem_wdata), 32'(m_wd));
                end
                if (e == issue_edge + 2) begin
                    if (!m_op) m_rdata = mem_fn(m_addr);
                    chk("rnd_val", 32'(val_data), 32'(1 << m_id));
                    grants++;
                end else begin
                    chk("rnd_val_idle", 32'(val_data), 32'(0));
                end
                chk("rnd_rdata",     32'(rdata),     32'(m_rdata));
                chk("rnd_proto_err", 32'(proto_err), 32'(0));

                for (int k = 0; k < N; k++) begin
                    if (val_data[k]) begin
                        req_ld[k] = 1'b0;
                        req_st[k] = 1'b0;
                    end else if (!(req_ld[k] || req_st[k])) begin
                        if ($urandom_range(0, 3) == 0) begin
                            op = 1'($urandom_range(0, 1));
                            set_core(k, ~op, op, 12'($urandom), 8'($urandom));
                        end
                    end else if ($urandom_range(0, 7) == 0) begin
                        core_addr[k*AW +: AW]  = 12'($urandom);
                        core_wdata[k*DW +: DW] = 8'($urandom);
                    end
                end
            end
            chk("rnd_grants_seen", 32'(grants > 50), 32'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
